// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART port arbiter.
package uart_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin pick: with both pending, the requester
// that was not granted last wins. Result is one-hot (zero when none pending).
module rr_pick2 (
  input  logic [1:0] i_pending,
  input  logic       i_last_grant,
  output logic [1:0] o_pick
);

  always_comb begin
    o_pick = 2'b00;
    case (i_pending)
      2'b01:   o_pick = 2'b01;
      2'b10:   o_pick = 2'b10;
      2'b11:   o_pick = i_last_grant ? 2'b01 : 2'b10;
      default: o_pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_port_arbiter.sv
// Shares one UART bus-side port between two requesters: serialises transactions,
// issues one-cycle strobes, returns exactly one response per transaction.
module uart_port_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_read,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_address,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_write_data,
  output logic [NUM_REQ-1:0]              resp_valid,
  output logic [NUM_REQ-1:0]              resp_error,
  output logic [NUM_REQ-1:0][DATA_W-1:0]  resp_read_data,
  output logic [NUM_REQ-1:0]              grant,
  output logic                            uart_read,
  output logic                            uart_write,
  output logic [DATA_W-1:0]               uart_address,
  output logic [DATA_W-1:0]               uart_write_data,
  input  logic                            uart_read_response,
  input  logic                            uart_write_response,
  input  logic [DATA_W-1:0]               uart_read_data
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t r_state, w_state_n;
  logic                            r_last_grant;
  logic                            r_owner;
  logic                            r_op;
  logic [NUM_REQ-1:0]              r_grant;
  logic [DATA_W-1:0]               r_addr;
  logic [DATA_W-1:0]               r_wdata;
  logic [CNT_W-1:0]                r_cnt;
  logic [NUM_REQ-1:0]              r_resp_valid;
  logic [NUM_REQ-1:0]              r_resp_error;
  logic [NUM_REQ-1:0][DATA_W-1:0]  r_resp_data;

  logic [NUM_REQ-1:0] w_pending;
  logic [NUM_REQ-1:0] w_pick;
  logic               w_pick_idx;
  logic               w_rsp_match;
  logic               w_rsp_any;
  logic               w_timeout;

  assign w_pending   = req_read | req_write;
  assign w_pick_idx  = w_pick[1];
  assign w_rsp_match = (r_op == OP_WRITE) ? uart_write_response : uart_read_response;
  assign w_rsp_any   = uart_read_response | uart_write_response;
  // Fires on the cycle the counter would reach its terminal count.
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_MAX - CNT_W'(1));

  rr_pick2 u_pick (
    .i_pending    (w_pending),
    .i_last_grant (r_last_grant),
    .o_pick       (w_pick)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (|w_pending) w_state_n = ISSUE;
      ISSUE:   w_state_n = WAIT;
      WAIT:    if (w_rsp_match || w_timeout) w_state_n = DRAIN;
      DRAIN:   if (!w_rsp_any) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_op         <= OP_READ;
      r_grant      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_resp_valid <= '0;
      r_resp_error <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= '0;
      r_resp_error <= '0;
      r_resp_data  <= '0;
      case (r_state)
        IDLE: if (|w_pending) begin
          r_owner <= w_pick_idx;
          r_grant <= w_pick;
          // A simultaneous read stays pending behind the write.
          r_op    <= req_write[w_pick_idx] ? OP_WRITE : OP_READ;
          r_addr  <= req_address[w_pick_idx];
          r_wdata <= req_write_data[w_pick_idx];
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          if (w_rsp_match) begin
            r_resp_valid[r_owner] <= 1'b1;
            if (r_op == OP_READ) r_resp_data[r_owner] <= uart_read_data;
          end else if (w_timeout) begin
            r_resp_valid[r_owner] <= 1'b1;
            r_resp_error[r_owner] <= 1'b1;
          end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DRAIN: if (!w_rsp_any) begin
          r_grant      <= '0;
          r_last_grant <= r_owner;
        end
        default: ;
      endcase
    end
  end

  assign grant           = r_grant;
  assign uart_read       = (r_state == ISSUE) && (r_op == OP_READ);
  assign uart_write      = (r_state == ISSUE) && (r_op == OP_WRITE);
  assign uart_address    = r_addr;
  assign uart_write_data = r_wdata;
  assign resp_valid      = r_resp_valid;
  assign resp_error      = r_resp_error;
  assign resp_read_data  = r_resp_data;

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed bench for uart_port_arbiter: arbitration order, op priority,
// single response per transaction, timeout and mid-transaction reset.
module tb_uart_port_arbiter;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_read, req_write;
  logic [1:0][31:0]  req_address, req_write_data;
  logic [1:0]        resp_valid, resp_error;
  logic [1:0][31:0]  resp_read_data;
  logic [1:0]        grant;
  logic              uart_read, uart_write;
  logic [31:0]       uart_address, uart_write_data;
  logic              uart_read_response, uart_write_response;
  logic [31:0]       uart_read_data;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  uart_port_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_read            (req_read),
    .req_write           (req_write),
    .req_address         (req_address),
    .req_write_data      (req_write_data),
    .resp_valid          (resp_valid),
    .resp_error          (resp_error),
    .resp_read_data      (resp_read_data),
    .grant               (grant),
    .uart_read           (uart_read),
    .uart_write          (uart_write),
    .uart_address        (uart_address),
    .uart_write_data     (uart_write_data),
    .uart_read_response  (uart_read_response),
    .uart_write_response (uart_write_response),
    .uart_read_data      (uart_read_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Requests must already be driven; the arbiter issues at the next posedge.
  // UART answers with a 2-cycle response; the requester drops its op on resp_valid.
  task automatic txn(input int who, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input string tag);
    logic [1:0] g;
    g = (who == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    chk({tag, "_grant"},  32'(grant), 32'(g));
    chk({tag, "_strobe"}, {30'd0, uart_write, uart_read}, wr ? 32'd2 : 32'd1);
    chk({tag, "_addr"},   uart_address, addr);
    if (wr) chk({tag, "_wdata"}, uart_write_data, wdata);
    @(negedge clk);
    chk({tag, "_strobe_off"}, {30'd0, uart_write, uart_read}, 32'd0);
    if (wr) uart_write_response = 1'b1;
    else begin
      uart_read_response = 1'b1;
      uart_read_data     = rdata;
    end
    @(negedge clk);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'(g));
    chk({tag, "_resp_error"}, 32'(resp_error), 32'd0);
    chk({tag, "_resp_data"},  resp_read_data[who], wr ? 32'd0 : rdata);
    if (wr) req_write[who] = 1'b0;
    else    req_read[who]  = 1'b0;
    @(negedge clk);
    chk({tag, "_single_resp"}, 32'(resp_valid), 32'd0);
    chk({tag, "_grant_drain"}, 32'(grant), 32'(g));
    chk({tag, "_addr_stable"}, uart_address, addr);
    uart_read_response  = 1'b0;
    uart_write_response = 1'b0;
    uart_read_data      = 32'hA5A5_A5A5;
    @(negedge clk);
    chk({tag, "_grant_idle"}, 32'(grant), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;
    reset = 1'b1;
    req_read = '0; req_write = '0;
    req_address = '0; req_write_data = '0;
    uart_read_response = 1'b0; uart_write_response = 1'b0;
    uart_read_data = 32'hA5A5_A5A5;
    repeat (2) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_strobe", {30'd0, uart_write, uart_read}, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_addr", uart_address, 32'd0);
    reset = 1'b0;

    // Simultaneous writes: requester 0 wins first after reset.
    req_write = 2'b11;
    req_address[0] = 32'h0000_0100; req_write_data[0] = 32'h1111_1111;
    req_address[1] = 32'h0000_0200; req_write_data[1] = 32'h2222_2222;
    txn(0, 1'b1, 32'h0000_0100, 32'h1111_1111, 32'h0, "wr0");
    txn(1, 1'b1, 32'h0000_0200, 32'h2222_2222, 32'h0, "wr1");

    // Single read from requester 0.
    req_read[0] = 1'b1; req_address[0] = 32'h0000_0010;
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, "rd0");

    // Requester 1 with read and write both high: write first, then read.
    req_read[1] = 1'b1; req_write[1] = 1'b1;
    req_address[1] = 32'h0000_0020; req_write_data[1] = 32'h3333_3333;
    txn(1, 1'b1, 32'h0000_0020, 32'h3333_3333, 32'h0, "rw1_w");
    txn(1, 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, "rw1_r");

    // Silent UART: timeout response 17 cycles after the strobe.
    req_read[0] = 1'b1; req_address[0] = 32'h0000_0040;
    uart_read_data = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("to_strobe", 32'(uart_read), 32'd1);
    pulses = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) pulses++;
    end
    chk("to_no_early_resp", 32'(pulses), 32'd0);
    @(negedge clk);
    chk("to_resp_valid", 32'(resp_valid), 32'd1);
    chk("to_resp_error", 32'(resp_error), 32'd1);
    chk("to_resp_data", resp_read_data[0], 32'd0);
    req_read[0] = 1'b0;
    @(negedge clk);
    chk("to_single_resp", 32'(resp_valid), 32'd0);
    chk("to_idle", 32'(grant), 32'd0);

    // Reset during WAIT of a requester-0 read (last_grant is 0 beforehand).
    req_read[0] = 1'b1; req_address[0] = 32'h0000_0050;
    @(negedge clk);
    chk("rw_issue", 32'(uart_read), 32'd1);
    @(negedge clk);
    reset = 1'b1; req_read[0] = 1'b0;
    @(negedge clk);
    chk("rw_grant", 32'(grant), 32'd0);
    chk("rw_strobe", {30'd0, uart_write, uart_read}, 32'd0);
    chk("rw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rw_addr", uart_address, 32'd0);
    reset = 1'b0;

    // Both read: requester 0 must win again, showing last_grant reset to 1.
    req_read = 2'b11;
    req_address[0] = 32'h0000_0060; req_address[1] = 32'h0000_0070;
    txn(0, 1'b0, 32'h0000_0060, 32'h0, 32'h1234_5678, "post0");
    txn(1, 1'b0, 32'h0000_0070, 32'h0, 32'h8765_4321, "post1");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
